// File: rtl/fft_bfly_sequencer_if.sv
// fft_bfly_sequencer_if: butterfly command channel between sequencer and FFT datapath
interface fft_bfly_sequencer_if #(
  parameter int NBITS = 5,
  parameter int N = 8
);
  localparam int AW = $clog2(N);
  localparam int SW = AW > 1 ? $clog2(AW) : 1;
  logic bf_valid;
  logic bf_ready;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [SW-1:0] stage;
  logic [NBITS-1:0] tw_re;
  logic [NBITS-1:0] tw_im;
  modport master (output bf_valid, addr_a, addr_b, stage, tw_re, tw_im, input bf_ready);
  modport slave (input bf_valid, addr_a, addr_b, stage, tw_re, tw_im, output bf_ready);
endinterface

// File: rtl/fft_bfly_sequencer.sv
// fft_bfly_sequencer: walks all radix-2 DIT stages issuing butterfly commands with a drain gap per stage
module fft_bfly_sequencer #(
  parameter int NBITS = 5,
  parameter int N = 8,
  parameter int BF_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [NBITS*N*2-1:0] coeff_data,
  fft_bfly_sequencer_if.master bf,
  output logic busy,
  output logic done
);
  localparam int AW = $clog2(N);
  localparam int SW = AW > 1 ? $clog2(AW) : 1;
  localparam int JW = AW - 1;
  localparam int DW = BF_LAT > 1 ? $clog2(BF_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n, state_adv;
  logic [SW-1:0] s, s_n, s_adv, s_e;
  logic [JW-1:0] j, j_n;
  logic [DW-1:0] d, d_n;
  logic last_j, last_s, last_d;
  logic [AW-1:0] jx, half, pos, k, addr_a;
  logic [2*NBITS-1:0] tw [N];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      s           <= '0;
      j           <= '0;
      d           <= '0;
      bf.bf_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      s           <= s_n;
      j           <= j_n;
      d           <= d_n;
      bf.bf_valid <= state_n == ISSUE;
      busy        <= state_n != IDLE;
      done        <= state_n == DONE;
    end
  assign last_j = j == JW'(N/2 - 1);
  assign last_s = s == SW'(AW - 1);
  assign last_d = d == DW'(BF_LAT > 0 ? BF_LAT - 1 : 0);
  assign state_adv = last_s ? DONE : ISSUE;
  assign s_adv = last_s ? '0 : s + 1'b1;
  always_comb begin
    state_n = state;
    s_n = s;
    j_n = j;
    d_n = d;
    case (state)
      IDLE: state_n = start ? ISSUE : IDLE;
      ISSUE: if (bf.bf_ready) begin
        j_n = last_j ? '0 : j + 1'b1;
        if (last_j && BF_LAT > 0) state_n = DRAIN;
        else if (last_j) begin
          state_n = state_adv;
          s_n = s_adv;
        end
      end
      DRAIN: begin
        d_n = last_d ? '0 : d + 1'b1;
        state_n = last_d ? state_adv : DRAIN;
        s_n = last_d ? s_adv : s;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      s_n = '0;
      j_n = '0;
      d_n = '0;
    end
  end
  // outside ISSUE the address path is forced to stage 0, butterfly 0
  assign s_e = bf.bf_valid ? s : '0;
  assign jx = bf.bf_valid ? {1'b0, j} : '0;
  assign half = AW'(1) << s_e;
  assign pos = jx & (half - AW'(1));
  assign addr_a = (((jx >> s_e) << 1) << s_e) | pos;
  assign k = pos << (SW'(AW - 1) - s_e);
  assign bf.addr_a = addr_a;
  assign bf.addr_b = addr_a | half;
  assign bf.stage = s_e;
  assign {bf.tw_re, bf.tw_im} = tw[k];
  for (genvar g = 0; g < N; g++) begin : g_tw
    assign tw[g] = coeff_data[2*NBITS*(N-g)-1 -: 2*NBITS];
  end
endmodule
